// File: rtl/unpack_uart_tx.sv
// Pops one wide word from a FIFO and sends it as NBYTES back-to-back
// UART frames (8N1 style), least-significant byte and bit first.
module unpack_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 256,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] data_in,
   input  logic                  check_empty,
   output logic                  read_enable,
   output logic                  tx,
   output logic                  busy,
   output logic                  word_done
);

   localparam int CPB    = CLK_FREQ / BAUD_RATE;
   localparam int NBYTES = WORD_WIDTH / DATA_WIDTH;
   localparam int CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        baud_q, baud_d;
   logic [BIT_W-1:0]        bit_q, bit_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [WORD_WIDTH-1:0]   word_q, word_d;
   logic [DATA_WIDTH-1:0]   sh_q, sh_d;
   logic                    tx_q, tx_d;
   logic                    re_q, re_d;
   logic                    busy_q, busy_d;
   logic                    wd_q, wd_d;
   logic                    baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      word_d  = word_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      re_d    = 1'b0;
      wd_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!check_empty) begin
               state_d = FETCH;
            end
         end

         // Two cycles: pop strobe, then let the FIFO present its word.
         FETCH: begin
            if (baud_q == '0) begin
               re_d   = 1'b1;
               baud_d = CNT_W'(1);
            end else begin
               baud_d  = '0;
               state_d = LOAD;
            end
         end

         LOAD: begin
            word_d  = data_in;
            sh_d    = data_in[DATA_WIDTH-1:0];
            idx_d   = '0;
            bit_d   = '0;
            baud_d  = '0;
            tx_d    = 1'b0;
            state_d = START;
         end

         START: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = sh_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
                  sh_d  = sh_q >> 1;
                  tx_d  = sh_d[0];
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end

         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  wd_d    = 1'b1;
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  sh_d    = word_q[int'(idx_d)*DATA_WIDTH +: DATA_WIDTH];
                  tx_d    = 1'b0;
                  state_d = START;
               end
            end else begin
               baud_d = baud_q + CNT_W'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         wd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
         wd_q    <= wd_d;
      end
   end

   assign tx          = tx_q;
   assign read_enable = re_q;
   assign busy        = busy_q;
   assign word_done   = wd_q;

endmodule
